// File: rtl/matrix_multiply_engine.sv
// Row-by-column matrix multiply engine: one (i,j) dot product issued per cycle over
// SIZE_COUNT lanes, results gathered into a double-buffered row and written per row of C.
module matrix_multiply_engine #(
    parameter int SIZE_COUNT   = 8,
    parameter int SIZE_WIDTH   = $clog2(SIZE_COUNT),
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int SATURATE     = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [1:0][SIZE_WIDTH-1:0]            mat_a_size,
    input  logic [1:0][SIZE_WIDTH-1:0]            mat_b_size,
    output logic [ADDR_WIDTH-1:0]                 mat_a_address,
    input  logic [SIZE_COUNT-1:0][DATA_WIDTH-1:0] mat_a_read_data,
    output logic [ADDR_WIDTH-1:0]                 mat_b_address,
    input  logic [SIZE_COUNT-1:0][DATA_WIDTH-1:0] mat_b_read_data,
    output logic                                  mat_c_write,
    output logic [ADDR_WIDTH-1:0]                 mat_c_address,
    output logic [SIZE_COUNT-1:0][DATA_WIDTH-1:0] mat_c_write_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  size_error
);

    localparam int SUM_W = 2 * DATA_WIDTH + SIZE_WIDTH;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [SIZE_WIDTH-1:0] row;
        logic [SIZE_WIDTH-1:0] col;
        logic                  last_col;
        logic                  last_row;
    } tag_t;

    state_t state, state_next;

    logic                  accept, reject, issue, issue_last, finish;
    logic [SIZE_WIDTH-1:0] m_dim, k_dim, n_dim;
    logic [SIZE_WIDTH-1:0] issue_i, issue_j;
    logic                  done_q, error_q;

    tag_t                  issue_tag;
    tag_t                  rd_tag [READ_LATENCY];
    tag_t                  p_tag;
    logic signed [SUM_W-1:0] lane_sum, p_sum;

    logic [DATA_WIDTH-1:0] row_buf [2][SIZE_COUNT];
    logic                  wr_valid, wr_last, wr_bank;
    logic [SIZE_WIDTH-1:0] wr_row;

    function automatic logic [DATA_WIDTH-1:0] convert_sum(input logic signed [SUM_W-1:0] s);
        logic [DATA_WIDTH-1:0] r;
        r = s[DATA_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (s > SAT_MAX) begin
                r = SAT_MAX[DATA_WIDTH-1:0];
            end else if (s < SAT_MIN) begin
                r = SAT_MIN[DATA_WIDTH-1:0];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mat_a_size[1] == mat_b_size[0]) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                issue = 1'b1;
                if (issue_i == m_dim && issue_j == n_dim) begin
                    issue_last = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_valid && wr_last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_dim   <= '0;
            k_dim   <= '0;
            n_dim   <= '0;
            issue_i <= '0;
            issue_j <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= finish;
            error_q <= reject;
            if (accept) begin
                m_dim   <= mat_a_size[0];
                k_dim   <= mat_a_size[1];
                n_dim   <= mat_b_size[1];
                issue_i <= '0;
                issue_j <= '0;
            end else if (issue) begin
                if (issue_last) begin
                    issue_i <= '0;
                    issue_j <= '0;
                end else if (issue_j == n_dim) begin
                    issue_j <= '0;
                    issue_i <= issue_i + 1'b1;
                end else begin
                    issue_j <= issue_j + 1'b1;
                end
            end
        end
    end

    always_comb begin
        issue_tag          = '0;
        issue_tag.valid    = issue;
        issue_tag.row      = issue_i;
        issue_tag.col      = issue_j;
        issue_tag.last_col = (issue_j == n_dim);
        issue_tag.last_row = issue_last;
    end

    // Lanes beyond K are masked so stale memory contents never reach the sum.
    always_comb begin
        logic signed [DATA_WIDTH-1:0]   a_el, b_el;
        logic signed [2*DATA_WIDTH-1:0] prod;
        lane_sum = '0;
        a_el     = '0;
        b_el     = '0;
        prod     = '0;
        for (int unsigned k = 0; k < SIZE_COUNT; k++) begin
            if (k <= 32'(k_dim)) begin
                a_el     = mat_a_read_data[k];
                b_el     = mat_b_read_data[k];
                prod     = (2 * DATA_WIDTH)'(a_el) * (2 * DATA_WIDTH)'(b_el);
                lane_sum = lane_sum + SUM_W'(prod);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                rd_tag[s] <= '0;
            end
            p_tag <= '0;
            p_sum <= '0;
        end else begin
            rd_tag[0] <= issue_tag;
            for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                rd_tag[s] <= rd_tag[s-1];
            end
            p_tag <= rd_tag[READ_LATENCY-1];
            p_sum <= lane_sum;
        end
    end

    // Bank chosen by row parity: row i+1 fills the other bank while row i is written out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < SIZE_COUNT; k++) begin
                    row_buf[b][k] <= '0;
                end
            end
            wr_valid <= 1'b0;
            wr_last  <= 1'b0;
            wr_bank  <= 1'b0;
            wr_row   <= '0;
        end else begin
            if (p_tag.valid) begin
                row_buf[p_tag.row[0]][p_tag.col] <= convert_sum(p_sum);
            end
            wr_valid <= p_tag.valid && p_tag.last_col;
            wr_last  <= p_tag.valid && p_tag.last_row;
            if (p_tag.valid && p_tag.last_col) begin
                wr_bank <= p_tag.row[0];
                wr_row  <= p_tag.row;
            end
        end
    end

    always_comb begin
        mat_c_write_data = '0;
        for (int unsigned k = 0; k < SIZE_COUNT; k++) begin
            if (wr_valid && k <= 32'(n_dim)) begin
                mat_c_write_data[k] = row_buf[wr_bank][k];
            end
        end
    end

    assign mat_a_address = ADDR_WIDTH'(issue_i);
    assign mat_b_address = ADDR_WIDTH'(issue_j);
    assign mat_c_write   = wr_valid;
    assign mat_c_address = wr_valid ? ADDR_WIDTH'(wr_row) : '0;
    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign size_error    = error_q;

endmodule

// File: tb/tb_matrix_multiply_engine.sv
// Directed bench for matrix_multiply_engine: two instances (latency 1 saturating,
// latency 3 truncating) sharing one behavioural A/B memory.
module tb_matrix_multiply_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, start1, start3;
    logic [1:0][2:0] a_size, b_size;
    logic [7:0][15:0] mem_a [8];
    logic [7:0][15:0] mem_b [8];

    logic [31:0]      r1_a_addr, r1_b_addr, r1_c_addr, r3_a_addr, r3_b_addr, r3_c_addr;
    logic [7:0][15:0] r1_a_data, r1_b_data, r1_c_data, r3_a_data, r3_b_data, r3_c_data;
    logic             r1_c_write, r1_busy, r1_done, r1_err;
    logic             r3_c_write, r3_busy, r3_done, r3_err;

    matrix_multiply_engine #(.READ_LATENCY(1), .SATURATE(1)) u_rl1 (
        .clk(clk), .reset(reset), .start(start1),
        .mat_a_size(a_size), .mat_b_size(b_size),
        .mat_a_address(r1_a_addr), .mat_a_read_data(r1_a_data),
        .mat_b_address(r1_b_addr), .mat_b_read_data(r1_b_data),
        .mat_c_write(r1_c_write), .mat_c_address(r1_c_addr), .mat_c_write_data(r1_c_data),
        .busy(r1_busy), .done(r1_done), .size_error(r1_err)
    );

    matrix_multiply_engine #(.READ_LATENCY(3), .SATURATE(0)) u_rl3 (
        .clk(clk), .reset(reset), .start(start3),
        .mat_a_size(a_size), .mat_b_size(b_size),
        .mat_a_address(r3_a_addr), .mat_a_read_data(r3_a_data),
        .mat_b_address(r3_b_addr), .mat_b_read_data(r3_b_data),
        .mat_c_write(r3_c_write), .mat_c_address(r3_c_addr), .mat_c_write_data(r3_c_data),
        .busy(r3_busy), .done(r3_done), .size_error(r3_err)
    );

    // Synchronous read memories with 1 and 3 cycles of latency.
    logic [2:0] r1_ah, r1_bh;
    logic [2:0] r3_ah [3];
    logic [2:0] r3_bh [3];
    always @(posedge clk) begin
        r1_ah    <= r1_a_addr[2:0];
        r1_bh    <= r1_b_addr[2:0];
        r3_ah[0] <= r3_a_addr[2:0];
        r3_bh[0] <= r3_b_addr[2:0];
        r3_ah[1] <= r3_ah[0];
        r3_bh[1] <= r3_bh[0];
        r3_ah[2] <= r3_ah[1];
        r3_bh[2] <= r3_bh[1];
    end
    assign r1_a_data = mem_a[r1_ah];
    assign r1_b_data = mem_b[r1_bh];
    assign r3_a_data = mem_a[r3_ah[2]];
    assign r3_b_data = mem_b[r3_bh[2]];

    int sel = 1;
    logic [31:0]      m_a_addr, m_b_addr, m_c_addr;
    logic [7:0][15:0] m_c_data;
    logic             m_write, m_busy, m_done, m_err;
    assign m_a_addr = (sel == 3) ? r3_a_addr  : r1_a_addr;
    assign m_b_addr = (sel == 3) ? r3_b_addr  : r1_b_addr;
    assign m_c_addr = (sel == 3) ? r3_c_addr  : r1_c_addr;
    assign m_c_data = (sel == 3) ? r3_c_data  : r1_c_data;
    assign m_write  = (sel == 3) ? r3_c_write : r1_c_write;
    assign m_busy   = (sel == 3) ? r3_busy    : r1_busy;
    assign m_done   = (sel == 3) ? r3_done    : r1_done;
    assign m_err    = (sel == 3) ? r3_err     : r1_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 3) start3 = v;
        else          start1 = v;
    endtask

    int done_cyc, first_wr, wr_cnt, issue_err, err_seen;
    logic [7:0][15:0] cap [8];

    // Call mid-cycle; that cycle is the start cycle (cycle 0).
    task automatic run_op(input int limit, input int n_issues, input bit busy_poke);
        int cyc;
        int nn;
        nn = int'(b_size[1]) + 1;
        set_start(1'b1);
        done_cyc = -1; first_wr = -1; wr_cnt = 0; issue_err = 0; err_seen = 0;
        for (int r = 0; r < 8; r++) cap[r] = '0;
        @(negedge clk);
        set_start(1'b0);
        cyc = 1;
        while (cyc <= limit && done_cyc < 0) begin
            if (cyc <= n_issues) begin
                if (m_a_addr != 32'((cyc - 1) / nn) || m_b_addr != 32'((cyc - 1) % nn) || !m_busy)
                    issue_err++;
            end
            if (m_err) err_seen++;
            if (m_write) begin
                if (first_wr < 0) first_wr = cyc;
                cap[m_c_addr[2:0]] = m_c_data;
                wr_cnt++;
            end
            if (m_done) begin
                done_cyc = cyc;
            end else begin
                if (busy_poke && cyc == 2) begin
                    set_start(1'b1);
                    a_size[0] = 3'd0; a_size[1] = 3'd2;
                    b_size[0] = 3'd0; b_size[1] = 3'd0;
                end else begin
                    set_start(1'b0);
                end
                @(negedge clk);
                cyc++;
            end
        end
        set_start(1'b0);
    endtask

    task automatic set_sizes(input int am, input int ak, input int bk, input int bn);
        a_size[0] = 3'(am); a_size[1] = 3'(ak);
        b_size[0] = 3'(bk); b_size[1] = 3'(bn);
    endtask

    task automatic load_2x2();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                mem_a[r][k] = 16'h1234;
                mem_b[r][k] = 16'h4321;
            end
        end
        mem_a[0][0] = 16'd1; mem_a[0][1] = 16'd2;
        mem_a[1][0] = 16'd3; mem_a[1][1] = 16'd4;
        mem_b[0][0] = 16'd5; mem_b[0][1] = 16'd7;
        mem_b[1][0] = 16'd6; mem_b[1][1] = 16'd8;
        set_sizes(1, 1, 1, 1);
    endtask

    task automatic check_2x2(input string tag);
        logic [7:0][15:0] e0, e1;
        e0 = '0; e0[0] = 16'd19; e0[1] = 16'd22;
        e1 = '0; e1[0] = 16'd43; e1[1] = 16'd50;
        check_eq({tag, "_done_cycle"}, 128'(done_cyc), 128'(8));
        check_eq({tag, "_first_write"}, 128'(first_wr), 128'(5));
        check_eq({tag, "_write_count"}, 128'(wr_cnt), 128'(2));
        check_eq({tag, "_row0"}, cap[0], e0);
        check_eq({tag, "_row1"}, cap[1], e1);
        check_eq({tag, "_issue_seq"}, 128'(issue_err), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0][15:0] e;
        int cnt, v;

        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        set_sizes(0, 0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            mem_a[r] = '0;
            mem_b[r] = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_busy_done_err", {r1_busy, r1_done, r1_err, r3_busy, r3_done, r3_err}, '0);
        check_eq("rst_write", {r1_c_write, r3_c_write}, '0);
        check_eq("rst_addr", {r1_a_addr, r1_b_addr, r3_a_addr, r3_b_addr}, '0);
        check_eq("rst_wdata", {r1_c_data, r1_c_addr}, '0);
        reset = 1'b0;
        @(negedge clk);

        // 2x2 with garbage in lanes above K, plus an ignored start while busy.
        sel = 1;
        load_2x2();
        run_op(20, 4, 1'b1);
        check_2x2("mm2x2");
        check_eq("mm2x2_no_size_error", 128'(err_seen), 128'(0));
        check_eq("mm2x2_busy_at_done", 128'(m_busy), 128'(0));

        // 1x1 [-3]x[5] started in the done cycle of the previous run.
        for (int k = 0; k < 8; k++) begin
            mem_a[0][k] = 16'h0777;
            mem_b[0][k] = 16'h0555;
        end
        mem_a[0][0] = 16'hFFFD;
        mem_b[0][0] = 16'd5;
        set_sizes(0, 0, 0, 0);
        run_op(12, 1, 1'b0);
        e = '0; e[0] = 16'hFFF1;
        check_eq("mm1x1_done_cycle", 128'(done_cyc), 128'(5));
        check_eq("mm1x1_first_write", 128'(first_wr), 128'(4));
        check_eq("mm1x1_write_count", 128'(wr_cnt), 128'(1));
        check_eq("mm1x1_row0", cap[0], e);

        // Inner dimension mismatch is rejected with a one-cycle pulse.
        @(negedge clk);
        set_sizes(2, 3, 2, 1);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check_eq("size_err_pulse", {m_err, m_busy}, 2'b10);
        @(negedge clk);
        check_eq("size_err_one_cycle", {m_err, m_busy}, 2'b00);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_write || m_busy || m_err) cnt++;
        end
        check_eq("size_err_no_activity", 128'(cnt), 128'(0));

        // Saturation at both rails with K=7 on the saturating instance.
        for (int k = 0; k < 8; k++) begin
            mem_a[0][k] = 16'h7FFF;
            mem_b[0][k] = 16'h7FFF;
        end
        set_sizes(0, 7, 7, 0);
        @(negedge clk);
        run_op(12, 1, 1'b0);
        e = '0; e[0] = 16'h7FFF;
        check_eq("sat_pos_row0", cap[0], e);
        check_eq("sat_pos_done_cycle", 128'(done_cyc), 128'(5));
        for (int k = 0; k < 8; k++) mem_a[0][k] = 16'h8000;
        @(negedge clk);
        run_op(12, 1, 1'b0);
        e = '0; e[0] = 16'h8000;
        check_eq("sat_neg_row0", cap[0], e);

        // Truncating instance keeps the low 16 bits of 8*0x3FFF0001.
        sel = 3;
        for (int k = 0; k < 8; k++) mem_a[0][k] = 16'h7FFF;
        @(negedge clk);
        run_op(16, 1, 1'b0);
        e = '0; e[0] = 16'h0008;
        check_eq("trunc_row0", cap[0], e);
        check_eq("trunc_done_cycle", 128'(done_cyc), 128'(7));

        // 8x8 identity times B at read latency 3: C must equal B.
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = '0;
            mem_a[i][i] = 16'd1;
            for (int k = 0; k < 8; k++) begin
                v = i * 300 - k * 77 + 5;
                mem_b[i][k] = v[15:0];
            end
        end
        set_sizes(7, 7, 7, 7);
        @(negedge clk);
        run_op(100, 64, 1'b0);
        check_eq("ident_done_cycle", 128'(done_cyc), 128'(70));
        check_eq("ident_first_write", 128'(first_wr), 128'(13));
        check_eq("ident_write_count", 128'(wr_cnt), 128'(8));
        check_eq("ident_issue_seq", 128'(issue_err), 128'(0));
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) e[j] = mem_b[j][i];
            check_eq($sformatf("ident_row%0d", i), cap[i], e);
        end

        // Reset during row 2 of a 4x4 run, with start held high to show reset wins.
        sel = 1;
        set_sizes(3, 3, 3, 3);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        cnt = 0;
        for (int c = 1; c < 10; c++) begin
            if (m_write) cnt++;
            @(negedge clk);
        end
        if (m_write) cnt++;
        reset = 1'b1;
        set_start(1'b1);
        @(negedge clk);
        check_eq("abort_busy_write", {m_busy, m_write}, 2'b00);
        reset = 1'b0;
        set_start(1'b0);
        repeat (10) begin
            @(negedge clk);
            if (m_write) cnt++;
            if (m_busy) cnt = cnt + 100;
        end
        check_eq("abort_write_total", 128'(cnt), 128'(1));

        load_2x2();
        @(negedge clk);
        run_op(20, 4, 1'b0);
        check_2x2("rerun2x2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_multiply_engine.md
MATRIX_MULTIPLY_ENGINE -- requirements
Module: matrix_multiply_engine

Interface
REQ-001 SHALL have parameter SIZE_COUNT, default 8: maximum matrix dimension and lane count.
REQ-002 SHALL have parameter SIZE_WIDTH, default $clog2(SIZE_COUNT): width of size fields.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 16: element width, two's-complement signed.
REQ-005 SHALL have parameter READ_LATENCY, default 1, range 1..4: cycles from address issue to read data valid.
REQ-006 SHALL have parameter SATURATE, default 1: 1 = saturate result to DATA_WIDTH, 0 = truncate to low bits.
REQ-007 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset; one clock domain.
REQ-008 SHALL have ports: start in 1, start request; mat_a_size in SIZE_WIDTH x2, A [rows-1, cols-1]; mat_b_size in SIZE_WIDTH x2, B [rows-1, cols-1].
REQ-009 SHALL have ports: mat_a_address out ADDR_WIDTH, A row index; mat_a_read_data in DATA_WIDTH x SIZE_COUNT, row of A.
REQ-010 SHALL have ports: mat_b_address out ADDR_WIDTH, B column index; mat_b_read_data in DATA_WIDTH x SIZE_COUNT, column of B (B stored column-major).
REQ-011 SHALL have ports: mat_c_write out 1, write strobe; mat_c_address out ADDR_WIDTH, C row index; mat_c_write_data out DATA_WIDTH x SIZE_COUNT, row of C.
REQ-012 SHALL have ports: busy out 1, operation in progress; done out 1, one-cycle completion pulse; size_error out 1, one-cycle rejection pulse.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; done SHALL pulse on the DRAIN -> IDLE cycle.
REQ-014 In IDLE with start=1 and mat_a_size[1]==mat_b_size[0]: latch M=mat_a_size[0], K=mat_a_size[1], N=mat_b_size[1]; enter RUN next cycle.
REQ-015 In IDLE with start=1 and mat_a_size[1]!=mat_b_size[0]: stay IDLE; size_error=1 for exactly the next cycle; no reads or writes.
REQ-016 start while busy=1 SHALL be ignored; size inputs SHALL be ignored outside the start cycle.
REQ-017 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-018 RUN SHALL issue one (i,j) pair per cycle, j fastest: j 0..N, then i+1; mat_a_address=i, mat_b_address=j, zero-extended.
REQ-019 After issuing (M,N), the FSM SHALL enter DRAIN; issue count SHALL be exactly (M+1)*(N+1).
REQ-020 Each lane SHALL compute a full-precision signed product; lanes k>K SHALL contribute zero.
REQ-021 Lane sum SHALL be held at 2*DATA_WIDTH+SIZE_WIDTH bits and registered one cycle after data valid: issue-to-product latency = READ_LATENCY+1.
REQ-022 Product (i,j) SHALL be stored in row buffer lane j, converted per SATURATE: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] or keep low DATA_WIDTH bits.
REQ-023 The cycle after product (i,N) is stored, mat_c_write SHALL be 1 for one cycle with mat_c_address=i, lanes 0..N = buffer, lanes >N = 0.
REQ-024 Issue SHALL continue without stalls across row boundaries; the row buffer SHALL be double-buffered so row i+1 products do not corrupt row i before its write.
REQ-025 DRAIN SHALL last until the write of row M; done SHALL coincide with the cycle after that write.
REQ-026 First-write latency = N+READ_LATENCY+3 cycles after the start cycle; total start-to-done = (M+1)*(N+1)+READ_LATENCY+3 cycles.
REQ-027 Degenerate 1x1 (all sizes 0) SHALL work: one issue, one write, done.
REQ-028 start may be reasserted in the cycle done pulses is asserted low-to-high; it SHALL be accepted on the following IDLE cycle.

Reset
REQ-029 reset=1 at any clock edge SHALL force IDLE and clear busy, done, size_error, mat_c_write, addresses and row buffers to 0.
REQ-030 reset mid-operation SHALL abort: no further mat_c_write; in-flight pipeline data SHALL be discarded.
REQ-031 reset SHALL take priority over start in the same cycle.

Verification
REQ-032 2x2 A=[[1,2],[3,4]], B=[[5,6],[7,8]], sizes [1,1]/[1,1], READ_LATENCY=1 -> writes row0 [19,22,0..], row1 [43,50,0..]; done at cycle 8 after start.
REQ-033 Sizes A [2,3], B [2,1] -> size_error one cycle, busy stays 0, no mat_c_write.
REQ-034 8x8 identity A, B random, READ_LATENCY=3 -> C==B row by row, 8 writes, no gaps in issue, done at cycle 70.
REQ-035 SATURATE=1, A row all 16'h7FFF, B column all 16'h7FFF, K=7 -> lane value 16'h7FFF; SATURATE=0 -> low 16 bits of 8*0x3FFF0001.
REQ-036 reset asserted during row 2 of 4x4 run -> busy=0 next cycle, no further writes; new start runs cleanly.
REQ-037 start pulsed while busy -> ignored, write count unchanged; 1x1 run [-3]x[5] -> single write lane0 = -15.
